// File: rtl/camera_zone_writer.sv
// Capture-path write engine: assigns each incoming frame to a free frame-buffer
// zone and queues one address/data write request per packed pixel word.
module camera_zone_writer #(
  parameter int FRAME_WORDS = 153600,
  parameter int RQ_DEPTH    = 8
) (
  input  logic        HCLK,
  input  logic        HReset_N,
  input  logic        CaptureEn,
  input  logic [31:0] BASE_ADDR_ZONE1,
  input  logic [31:0] BASE_ADDR_ZONE2,
  input  logic [31:0] BASE_ADDR_ZONE3,
  input  logic        DATAOK_ZONE1,
  input  logic        DATAOK_ZONE2,
  input  logic        DATAOK_ZONE3,
  input  logic        pix_valid,
  input  logic [31:0] pix_data,
  input  logic        pix_sof,
  input  logic        pix_eof,
  output logic        wreq_valid,
  output logic [31:0] wreq_addr,
  output logic [31:0] wreq_data,
  input  logic        wreq_ready,
  input  logic        wreq_busy,
  output logic [3:0]  RQCNT,
  output logic        RQOverFlow,
  output logic [1:0]  CurrentZone,
  output logic [1:0]  ProtocolErr,
  output logic        DATAOK_ZONE1_Set,
  output logic        DATAOK_ZONE2_Set,
  output logic        DATAOK_ZONE3_Set
);

  localparam int OFF_W = $clog2(FRAME_WORDS + 1);
  localparam int PTR_W = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_CAPTURE,
    S_SKIP,
    S_DRAIN
  } state_t;

  function automatic logic [1:0] next_zone(input logic [1:0] z);
    return (z == 2'd3) ? 2'd1 : z + 2'd1;
  endfunction

  function automatic logic zone_full(input logic [1:0] z, input logic ok1,
                                     input logic ok2, input logic ok3);
    case (z)
      2'd1:    return ok1;
      2'd2:    return ok2;
      2'd3:    return ok3;
      default: return 1'b1;
    endcase
  endfunction

  // Round-robin search starting after the last completed zone; 0 = none free.
  function automatic logic [1:0] pick_zone(input logic [1:0] last, input logic ok1,
                                           input logic ok2, input logic ok3);
    logic [1:0] c;
    logic [1:0] pick;
    c    = last;
    pick = 2'd0;
    for (int i = 0; i < 3; i++) begin
      c = next_zone(c);
      if (pick == 2'd0 && !zone_full(c, ok1, ok2, ok3)) pick = c;
    end
    return pick;
  endfunction

  function automatic logic [31:0] zone_base(input logic [1:0] z, input logic [31:0] b1,
                                            input logic [31:0] b2, input logic [31:0] b3);
    case (z)
      2'd1:    return b1;
      2'd2:    return b2;
      default: return b3;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       last_zone_q, last_zone_d;
  logic [1:0]       zone_q, zone_d;
  logic [1:0]       cur_zone_q, cur_zone_d;
  logic [31:0]      base_q, base_d;
  logic [OFF_W-1:0] offset_q, offset_d;
  logic             pend_skip_q, pend_skip_d;

  logic             push;
  logic [31:0]      push_addr;
  logic             err_sof, err_word;
  logic [1:0]       set_zone;
  logic             do_select;
  logic [1:0]       sel_zone;
  logic [31:0]      sel_base;

  logic [63:0]      rq_mem [RQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [3:0]       rq_cnt_q, rq_cnt_d;
  logic             rq_full, pop, push_ok, overflow;

  logic             ovf_p1;
  logic [1:0]       perr_p1;
  logic [3:1]       set_p1;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign sel_zone = pick_zone(last_zone_q, DATAOK_ZONE1, DATAOK_ZONE2, DATAOK_ZONE3);
  assign sel_base = zone_base(sel_zone, BASE_ADDR_ZONE1, BASE_ADDR_ZONE2, BASE_ADDR_ZONE3);

  always_comb begin
    state_d     = state_q;
    last_zone_d = last_zone_q;
    zone_d      = zone_q;
    cur_zone_d  = cur_zone_q;
    base_d      = base_q;
    offset_d    = offset_q;
    pend_skip_d = pend_skip_q;
    push        = 1'b0;
    push_addr   = base_q + (32'(offset_q) << 2);
    err_sof     = 1'b0;
    err_word    = 1'b0;
    set_zone    = 2'd0;
    do_select   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (CaptureEn) state_d = S_WAIT_SOF;
      end
      S_WAIT_SOF: begin
        if (pix_valid) begin
          if (pix_sof) do_select = 1'b1;
          else         err_word  = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (pix_valid) begin
          if (pix_sof) begin
            err_sof   = 1'b1;
            do_select = 1'b1;
          end else if (offset_q == OFF_W'(FRAME_WORDS)) begin
            err_word = 1'b1;
            if (pix_eof) state_d = S_DRAIN;
          end else begin
            push     = 1'b1;
            offset_d = offset_q + 1'b1;
            if (pix_eof) state_d = S_DRAIN;
          end
        end
      end
      S_SKIP: begin
        if (pix_valid) begin
          if (pix_sof)      do_select = 1'b1;
          else if (pix_eof) state_d   = S_WAIT_SOF;
        end
      end
      S_DRAIN: begin
        if (pix_valid) begin
          if (pix_sof) pend_skip_d = 1'b1;
          else         err_word    = 1'b1;
        end
        if (rq_cnt_q == 4'd0 && !wreq_busy) begin
          set_zone    = zone_q;
          last_zone_d = zone_q;
          cur_zone_d  = 2'd0;
          state_d     = pend_skip_d ? S_SKIP : S_WAIT_SOF;
          pend_skip_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_select) begin
      if (sel_zone != 2'd0) begin
        zone_d     = sel_zone;
        base_d     = sel_base;
        cur_zone_d = sel_zone;
        push       = 1'b1;
        push_addr  = sel_base;
        offset_d   = OFF_W'(1);
        state_d    = pix_eof ? S_DRAIN : S_CAPTURE;
      end else begin
        cur_zone_d = 2'd0;
        state_d    = S_SKIP;
      end
    end

    // Disabling capture overrides everything; queued writes still drain.
    if (!CaptureEn) begin
      state_d     = S_IDLE;
      cur_zone_d  = 2'd0;
      last_zone_d = last_zone_q;
      pend_skip_d = 1'b0;
      push        = 1'b0;
      err_sof     = 1'b0;
      err_word    = 1'b0;
      set_zone    = 2'd0;
    end
  end

  assign pop      = (rq_cnt_q != 4'd0) && wreq_ready;
  assign rq_full  = (rq_cnt_q == 4'(RQ_DEPTH));
  assign push_ok  = push && (!rq_full || pop);
  assign overflow = push && rq_full && !pop;

  always_comb begin
    rq_cnt_d = rq_cnt_q;
    case ({push_ok, pop})
      2'b10:   rq_cnt_d = rq_cnt_q + 4'd1;
      2'b01:   rq_cnt_d = rq_cnt_q - 4'd1;
      default: rq_cnt_d = rq_cnt_q;
    endcase
  end

  always_ff @(posedge HCLK or negedge HReset_N) begin
    if (!HReset_N) begin
      state_q     <= S_IDLE;
      last_zone_q <= 2'd3;
      zone_q      <= 2'd0;
      cur_zone_q  <= 2'd0;
      offset_q    <= '0;
      pend_skip_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rq_cnt_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      last_zone_q <= last_zone_d;
      zone_q      <= zone_d;
      cur_zone_q  <= cur_zone_d;
      offset_q    <= offset_d;
      pend_skip_q <= pend_skip_d;
      rq_cnt_q    <= rq_cnt_d;
      if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)     rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge HCLK) begin
    base_q <= base_d;
    if (push_ok) rq_mem[wr_ptr_q] <= {push_addr, pix_data};
  end

  // Stage p1: status pulses registered one cycle after their causing event.
  always_ff @(posedge HCLK or negedge HReset_N) begin
    if (!HReset_N) begin
      ovf_p1  <= 1'b0;
      perr_p1 <= 2'b00;
      set_p1  <= 3'b000;
    end else begin
      ovf_p1  <= overflow;
      perr_p1 <= {err_word, err_sof};
      set_p1  <= {set_zone == 2'd3, set_zone == 2'd2, set_zone == 2'd1};
    end
  end

  assign wreq_valid       = (rq_cnt_q != 4'd0);
  assign wreq_addr        = rq_mem[rd_ptr_q][63:32];
  assign wreq_data        = rq_mem[rd_ptr_q][31:0];
  assign RQCNT            = rq_cnt_q;
  assign RQOverFlow       = ovf_p1;
  assign CurrentZone      = cur_zone_q;
  assign ProtocolErr      = perr_p1;
  assign DATAOK_ZONE1_Set = set_p1[1];
  assign DATAOK_ZONE2_Set = set_p1[2];
  assign DATAOK_ZONE3_Set = set_p1[3];

endmodule

// File: tb/tb_camera_zone_writer.sv
// Directed bench for camera_zone_writer: scoreboarded write requests plus
// pulse counters, with a second instance built with a 4-word frame limit.
module tb_camera_zone_writer;

  logic        HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  logic        HReset_N, CaptureEn, cap2;
  logic [31:0] BASE_ADDR_ZONE1, BASE_ADDR_ZONE2, BASE_ADDR_ZONE3;
  logic        DATAOK_ZONE1, DATAOK_ZONE2, DATAOK_ZONE3;
  logic        pix_valid, pix_sof, pix_eof;
  logic [31:0] pix_data;
  logic        wreq_ready, wreq_busy;

  logic        wreq_valid, RQOverFlow;
  logic [31:0] wreq_addr, wreq_data;
  logic [3:0]  RQCNT;
  logic [1:0]  CurrentZone, ProtocolErr;
  logic        DATAOK_ZONE1_Set, DATAOK_ZONE2_Set, DATAOK_ZONE3_Set;

  logic        w2_valid, w2_ovf;
  logic [31:0] w2_addr, w2_data;
  logic [3:0]  w2_rqcnt;
  logic [1:0]  w2_zone, w2_perr;
  logic        w2_set1, w2_set2, w2_set3;

  camera_zone_writer dut (
    .HCLK(HCLK), .HReset_N(HReset_N), .CaptureEn(CaptureEn),
    .BASE_ADDR_ZONE1(BASE_ADDR_ZONE1), .BASE_ADDR_ZONE2(BASE_ADDR_ZONE2),
    .BASE_ADDR_ZONE3(BASE_ADDR_ZONE3),
    .DATAOK_ZONE1(DATAOK_ZONE1), .DATAOK_ZONE2(DATAOK_ZONE2), .DATAOK_ZONE3(DATAOK_ZONE3),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof), .pix_eof(pix_eof),
    .wreq_valid(wreq_valid), .wreq_addr(wreq_addr), .wreq_data(wreq_data),
    .wreq_ready(wreq_ready), .wreq_busy(wreq_busy),
    .RQCNT(RQCNT), .RQOverFlow(RQOverFlow), .CurrentZone(CurrentZone),
    .ProtocolErr(ProtocolErr),
    .DATAOK_ZONE1_Set(DATAOK_ZONE1_Set), .DATAOK_ZONE2_Set(DATAOK_ZONE2_Set),
    .DATAOK_ZONE3_Set(DATAOK_ZONE3_Set)
  );

  camera_zone_writer #(.FRAME_WORDS(4)) dut_fw4 (
    .HCLK(HCLK), .HReset_N(HReset_N), .CaptureEn(cap2),
    .BASE_ADDR_ZONE1(BASE_ADDR_ZONE1), .BASE_ADDR_ZONE2(BASE_ADDR_ZONE2),
    .BASE_ADDR_ZONE3(BASE_ADDR_ZONE3),
    .DATAOK_ZONE1(DATAOK_ZONE1), .DATAOK_ZONE2(DATAOK_ZONE2), .DATAOK_ZONE3(DATAOK_ZONE3),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof), .pix_eof(pix_eof),
    .wreq_valid(w2_valid), .wreq_addr(w2_addr), .wreq_data(w2_data),
    .wreq_ready(wreq_ready), .wreq_busy(wreq_busy),
    .RQCNT(w2_rqcnt), .RQOverFlow(w2_ovf), .CurrentZone(w2_zone),
    .ProtocolErr(w2_perr),
    .DATAOK_ZONE1_Set(w2_set1), .DATAOK_ZONE2_Set(w2_set2), .DATAOK_ZONE3_Set(w2_set3)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb1[$];
  wr_t sb2[$];
  int  checks = 0;
  int  errors = 0;
  int  ovf1, pe0_1, pe1_1, pe1_2, rq_at_set;
  int  set1 [4];
  int  set2 [4];

  localparam logic [31:0] B1 = 32'h1000_0000;
  localparam logic [31:0] B2 = 32'h2000_0000;
  localparam logic [31:0] B3 = 32'h3000_0000;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge HCLK) begin
    if (HReset_N) begin
      wr_t e;
      if (wreq_valid && wreq_ready) begin
        e = 'x;
        if (sb1.size() != 0) e = sb1.pop_front();
        chk("dut_wr_addr", wreq_addr, e.addr);
        chk("dut_wr_data", wreq_data, e.data);
      end
      if (w2_valid && wreq_ready) begin
        e = 'x;
        if (sb2.size() != 0) e = sb2.pop_front();
        chk("fw4_wr_addr", w2_addr, e.addr);
        chk("fw4_wr_data", w2_data, e.data);
      end
      if (RQOverFlow)     ovf1++;
      if (ProtocolErr[0]) pe0_1++;
      if (ProtocolErr[1]) pe1_1++;
      if (w2_perr[1])     pe1_2++;
      if (DATAOK_ZONE1_Set) begin set1[1]++; rq_at_set = int'(RQCNT); end
      if (DATAOK_ZONE2_Set) begin set1[2]++; rq_at_set = int'(RQCNT); end
      if (DATAOK_ZONE3_Set) begin set1[3]++; rq_at_set = int'(RQCNT); end
      if (w2_set1) set2[1]++;
      if (w2_set2) set2[2]++;
      if (w2_set3) set2[3]++;
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [31:0] d, input logic sof, input logic eof);
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
    pix_eof   = eof;
    tick();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_eof   = 1'b0;
  endtask

  task automatic exp1(input logic [31:0] a, input logic [31:0] d);
    sb1.push_back({a, d});
  endtask

  task automatic exp2(input logic [31:0] a, input logic [31:0] d);
    sb2.push_back({a, d});
  endtask

  task automatic clear_counts();
    ovf1 = 0; pe0_1 = 0; pe1_1 = 0; pe1_2 = 0; rq_at_set = -1;
    for (int i = 0; i < 4; i++) begin
      set1[i] = 0;
      set2[i] = 0;
    end
  endtask

  task automatic do_reset();
    HReset_N = 1'b0;
    tick();
    tick();
    HReset_N = 1'b1;
    clear_counts();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    HReset_N = 1'b0; CaptureEn = 1'b0; cap2 = 1'b0;
    BASE_ADDR_ZONE1 = B1; BASE_ADDR_ZONE2 = B2; BASE_ADDR_ZONE3 = B3;
    DATAOK_ZONE1 = 1'b0; DATAOK_ZONE2 = 1'b0; DATAOK_ZONE3 = 1'b0;
    pix_valid = 1'b0; pix_sof = 1'b0; pix_eof = 1'b0; pix_data = '0;
    wreq_ready = 1'b1; wreq_busy = 1'b0;
    clear_counts();
    tick();
    tick();
    chk("rst_wreq_valid", wreq_valid, 0);
    chk("rst_rqcnt", RQCNT, 0);
    chk("rst_ovf", RQOverFlow, 0);
    chk("rst_zone", CurrentZone, 0);
    chk("rst_perr", ProtocolErr, 0);
    chk("rst_set", {DATAOK_ZONE1_Set, DATAOK_ZONE2_Set, DATAOK_ZONE3_Set}, 0);
    HReset_N = 1'b1;
    tick();

    // Basic 4-word frame into zone 1; Set held off while AHB reports busy.
    CaptureEn = 1'b1; wreq_busy = 1'b1;
    tick();
    exp1(B1 + 32'h0, 32'hA0);
    send(32'hA0, 1'b1, 1'b0);
    chk("t1_latency_valid", wreq_valid, 1);
    chk("t1_latency_addr", wreq_addr, B1);
    chk("t1_zone", CurrentZone, 1);
    exp1(B1 + 32'h4, 32'hA1); send(32'hA1, 1'b0, 1'b0);
    exp1(B1 + 32'h8, 32'hA2); send(32'hA2, 1'b0, 1'b0);
    exp1(B1 + 32'hC, 32'hA3); send(32'hA3, 1'b0, 1'b1);
    idle(10);
    chk("t1_set_while_busy", set1[1], 0);
    chk("t1_zone_draining", CurrentZone, 1);
    wreq_busy = 1'b0;
    idle(5);
    chk("t1_set1", set1[1], 1);
    chk("t1_rqcnt_at_set", rq_at_set, 0);
    chk("t1_zone_after", CurrentZone, 0);
    chk("t1_sb_empty", sb1.size(), 0);

    // Zone rotation with zone 2 held full: 1, 3, 1, then nothing free.
    do_reset();
    DATAOK_ZONE2 = 1'b1;
    exp1(B1, 32'hB0); send(32'hB0, 1'b1, 1'b0);
    chk("t2_zone_a", CurrentZone, 1);
    exp1(B1 + 32'h4, 32'hB1); send(32'hB1, 1'b0, 1'b1);
    idle(8);
    exp1(B3, 32'hB2); send(32'hB2, 1'b1, 1'b0);
    chk("t2_zone_b", CurrentZone, 3);
    exp1(B3 + 32'h4, 32'hB3); send(32'hB3, 1'b0, 1'b1);
    idle(8);
    exp1(B1, 32'hB4); send(32'hB4, 1'b1, 1'b0);
    chk("t2_zone_c", CurrentZone, 1);
    exp1(B1 + 32'h4, 32'hB5); send(32'hB5, 1'b0, 1'b1);
    idle(8);
    chk("t2_set1", set1[1], 2);
    chk("t2_set2", set1[2], 0);
    chk("t2_set3", set1[3], 1);
    DATAOK_ZONE1 = 1'b1; DATAOK_ZONE3 = 1'b1;
    send(32'hB6, 1'b1, 1'b0);
    chk("t2_skip_zone", CurrentZone, 0);
    send(32'hB7, 1'b0, 1'b1);
    idle(8);
    chk("t2_skip_rqcnt", RQCNT, 0);
    chk("t2_skip_sets", set1[1] + set1[2] + set1[3], 3);
    chk("t2_skip_no_err", pe1_1, 0);
    chk("t2_sb_empty", sb1.size(), 0);
    DATAOK_ZONE1 = 1'b0; DATAOK_ZONE2 = 1'b0; DATAOK_ZONE3 = 1'b0;

    // Queue overflow: 10 words with the master stalled.
    do_reset();
    wreq_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) exp1(B1 + 32'(4 * i), 32'hC0 + 32'(i));
      send(32'hC0 + 32'(i), i == 0, i == 9);
    end
    chk("t3_rqcnt_full", RQCNT, 8);
    chk("t3_head_valid", wreq_valid, 1);
    chk("t3_head_addr", wreq_addr, B1);
    chk("t3_head_data", wreq_data, 32'hC0);
    idle(2);
    chk("t3_ovf_count", ovf1, 2);
    wreq_ready = 1'b1;
    idle(15);
    chk("t3_sb_empty", sb1.size(), 0);
    chk("t3_set1", set1[1], 1);
    chk("t3_rqcnt_at_set", rq_at_set, 0);

    // SOF mid-frame; zone 1 marked full meanwhile so the restart lands in zone 2.
    do_reset();
    exp1(B1, 32'hD0); send(32'hD0, 1'b1, 1'b0);
    DATAOK_ZONE1 = 1'b1;
    exp1(B1 + 32'h4, 32'hD1); send(32'hD1, 1'b0, 1'b0);
    exp1(B2, 32'hD2); send(32'hD2, 1'b1, 1'b0);
    chk("t4_zone", CurrentZone, 2);
    exp1(B2 + 32'h4, 32'hD3); send(32'hD3, 1'b0, 1'b0);
    exp1(B2 + 32'h8, 32'hD4); send(32'hD4, 1'b0, 1'b1);
    idle(10);
    chk("t4_perr0", pe0_1, 1);
    chk("t4_set1_none", set1[1], 0);
    chk("t4_set2", set1[2], 1);
    chk("t4_sb_empty", sb1.size(), 0);
    DATAOK_ZONE1 = 1'b0;

    // Stray word in WAIT_SOF, then a 6-word frame into the 4-word instance.
    do_reset();
    send(32'hE0, 1'b0, 1'b0);
    idle(3);
    chk("t5_stray_perr1", pe1_1, 1);
    chk("t5_stray_rqcnt", RQCNT, 0);
    CaptureEn = 1'b0; cap2 = 1'b1;
    idle(2);
    for (int i = 0; i < 6; i++) begin
      if (i < 4) exp2(B1 + 32'(4 * i), 32'hF0 + 32'(i));
      send(32'hF0 + 32'(i), i == 0, i == 5);
    end
    idle(10);
    chk("t5_fw4_perr1", pe1_2, 2);
    chk("t5_fw4_set1", set2[1], 1);
    chk("t5_fw4_sb_empty", sb2.size(), 0);
    chk("t5_fw4_zone", w2_zone, 0);
    cap2 = 1'b0;

    // CaptureEn dropped with three writes queued: they still issue, no Set.
    CaptureEn = 1'b1;
    tick();
    wreq_ready = 1'b0;
    exp1(B1, 32'h70); send(32'h70, 1'b1, 1'b0);
    exp1(B1 + 32'h4, 32'h71); send(32'h71, 1'b0, 1'b0);
    exp1(B1 + 32'h8, 32'h72); send(32'h72, 1'b0, 1'b0);
    CaptureEn = 1'b0;
    tick();
    chk("t6_zone", CurrentZone, 0);
    chk("t6_rqcnt", RQCNT, 3);
    wreq_ready = 1'b1;
    idle(8);
    chk("t6_sb_empty", sb1.size(), 0);
    chk("t6_no_set", set1[1] + set1[2] + set1[3], 0);
    send(32'h73, 1'b1, 1'b1);
    idle(3);
    chk("t6_idle_rqcnt", RQCNT, 0);
    chk("t6_idle_perr1", pe1_1, 1);
    chk("t6_idle_perr0", pe0_1, 0);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
